sd_cmd_sequencer: RTL and testbench
===================================

# sd_cmd_sequencer

Byte-level SD-card command engine in SPI mode, directly upstream of the 8-bit SPI shift stage. It builds the 6-byte command frame (start bits, index, argument, CRC7, stop bit) and feeds it to the shifter byte by byte. It then clocks 0xFF filler bytes while scanning the returned bytes for the R1 response, and optionally collects a 4-byte R3/R7 trailer. It controls chip-select and the shifter's clock enable, and reports the result to the SD controller FSM above it.

## Interface
- TIMEOUT_BYTES, 8: maximum filler bytes clocked while waiting for R1 (1..255).
- Clk  in  1  system clock; one clock domain; Clk ≥ 4× SPI clock.
- Reset  in  1  synchronous, active-high.
- Start  in  1  request; accepted only when Busy=0.
- CmdIndex  in  6  command index.
- CmdArg  in  32  command argument.
- RespLen  in  1  0 = R1 only; 1 = R1 plus 4 trailer bytes.
- HoldCs  in  1  1 = keep SdCsN low after Done, for a following data phase.
- ByteStrobe  in  1  1-cycle pulse, synchronized to Clk; one byte exchange just finished and RxByte is valid.
- RxByte  in  8  byte received by the shifter.
- TxByte  out  8  byte the shifter transmits next; reset 0xFF.
- SpiEnable  out  1  gates the SPI clock; reset 0.
- SdCsN  out  1  card select, active-low; reset 1.
- Busy  out  1  reset 0.
- Done  out  1  1-cycle pulse; reset 0.
- R1  out  8  last R1; reset 0xFF.
- RespData  out  32  trailer, MSB first; reset 0.
- Timeout  out  1  sticky until next accepted Start; reset 0.

## Operation
- States: IDLE → PRE → CMD → WAIT_R1 → (EXT) → POST → IDLE.
- IDLE
  - TxByte=0xFF; Busy=0; SpiEnable=0.
  - SdCsN=1 unless the last command had HoldCs=1.
- Start accepted in IDLE:
  - Latch CmdIndex, CmdArg, RespLen and HoldCs.
  - Clear Timeout.
  - Busy=1, SdCsN=0, SpiEnable=1, state=PRE.
- PRE: send one 0xFF byte. On ByteStrobe go to CMD with TxByte = {2'b01, CmdIndex}.
- CMD: byte counter 0..5.
  - Bytes 1–4 are CmdArg[31:24] .. CmdArg[7:0].
  - Byte 5 = {CRC7, 1'b1}. CRC7 uses polynomial x^7+x^3+1, initial value 0, over bytes 0–4.
  - The CRC is accumulated byte-serially as each byte is loaded.
  - On the strobe ending byte 5: TxByte=0xFF, wait counter=0, go to WAIT_R1.
- WAIT_R1: on each ByteStrobe:
  - RxByte[7]=0: R1=RxByte; go to EXT if RespLen=1, else POST.
  - Otherwise increment the counter. When it reaches TIMEOUT_BYTES: R1=0xFF, Timeout=1, skip EXT, go to POST.
  - R1 error bits are not interpreted; any MSB=0 byte ends the wait.
- EXT: 4 strobes. Each shifts RxByte into RespData: RespData <= {RespData[23:0], RxByte}. Then go to POST.
- POST: one trailing 0xFF byte. On its strobe:
  - SpiEnable=0; SdCsN = ~HoldCs; Done=1 for one cycle; Busy=0; go to IDLE.
- Start while Busy=1 is ignored (no queueing). Start coinciding with the Done cycle is also ignored.
- ByteStrobe in IDLE is ignored.
- Reset at any point: all outputs return to their reset values on the next edge and the state returns to IDLE. A byte in flight is abandoned.

## Timing
- All outputs registered.
- TxByte updates on the Clk edge that samples ByteStrobe, and is stable before the shifter's next byte boundary.
- Start → SdCsN low and SpiEnable high: 1 cycle.
- Total bytes per command = 1 + 6 + w + 4·RespLen + 1, where w = 1..TIMEOUT_BYTES is the number of wait bytes.
- Timeout case: exactly 8 + TIMEOUT_BYTES strobes.
- Done is asserted on the edge after the POST strobe. R1, RespData and Timeout are valid from that edge until the next accepted Start.

## Structure
- Shared package sd_spi_pkg:
  - Command constants: CMD0=0, CMD8=8, CMD17=17, CMD55=55, ACMD41=41.
  - State encoding.
  - Frame constants: START_BITS=2'b01, FILL_BYTE=8'hFF.
- Sub-module sd_crc7: byte-serial CRC7 with clear and byte-load, one byte per cycle. It is reused later for the data-block path.
- Byte counter is 3 bits. Wait counter is 8 bits.

## Test plan
- CMD0, arg 0, responder returns FF then 01:
  - TxByte sequence FF,40,00,00,00,00,95,FF,FF,FF.
  - R1=0x01, Timeout=0, Done pulse, then SdCsN=1 and SpiEnable=0.
- CMD8, arg 0x000001AA, RespLen=1, responder returns 01,00,00,01,AA:
  - CRC byte 0x87; R1=0x01; RespData=0x000001AA.
- MISO held at 0xFF:
  - Exactly 8 wait bytes, 16 strobes total.
  - Timeout=1, R1=0xFF, no EXT bytes even when RespLen=1.
- Start pulsed during CMD and on the Done cycle:
  - Ignored; the frame is unchanged and exactly one Done occurs.
- Reset asserted mid-CMD (byte 3):
  - Next cycle SdCsN=1, SpiEnable=0, TxByte=FF, Busy=0.
  - A following CMD0 completes normally.
- CMD17 with HoldCs=1, R1=00:
  - SdCsN stays 0 after Done.
  - The next command with HoldCs=0 releases it after its POST byte.

Source files
------------

// File: rtl/sd_spi_pkg.sv
// Shared SD-over-SPI definitions: command indices, frame constants, sequencer
// state encoding and the byte-serial CRC7 step.
package sd_spi_pkg;

   localparam logic [5:0] CMD0   = 6'd0;
   localparam logic [5:0] CMD8   = 6'd8;
   localparam logic [5:0] CMD17  = 6'd17;
   localparam logic [5:0] CMD55  = 6'd55;
   localparam logic [5:0] ACMD41 = 6'd41;

   localparam logic [1:0] START_BITS = 2'b01;
   localparam logic [7:0] FILL_BYTE  = 8'hFF;

   // x^7 + x^3 + 1 with the x^7 term implied
   localparam logic [6:0] CRC7_POLY = 7'h09;

   typedef enum logic [2:0] {
      StIdle,
      StPre,
      StCmd,
      StWaitR1,
      StExt,
      StPost
   } seq_state_e;

   function automatic logic [6:0] crc7_update(logic [6:0] crc, logic [7:0] data);
      logic [6:0] c;
      logic       fb;
      c = crc;
      for (int i = 7; i >= 0; i--) begin
         fb = c[6] ^ data[i];
         c  = {c[5:0], 1'b0};
         if (fb) c = c ^ CRC7_POLY;
      end
      return c;
   endfunction

endpackage

// File: rtl/sd_cmd_sequencer_if.sv
// Signal bundle between the SD controller / SPI shifter and the command sequencer.
interface sd_cmd_sequencer_if;

   logic        Start;
   logic [5:0]  CmdIndex;
   logic [31:0] CmdArg;
   logic        RespLen;
   logic        HoldCs;
   logic        ByteStrobe;
   logic [7:0]  RxByte;
   logic [7:0]  TxByte;
   logic        SpiEnable;
   logic        SdCsN;
   logic        Busy;
   logic        Done;
   logic [7:0]  R1;
   logic [31:0] RespData;
   logic        Timeout;

   modport master (
      output Start, CmdIndex, CmdArg, RespLen, HoldCs, ByteStrobe, RxByte,
      input  TxByte, SpiEnable, SdCsN, Busy, Done, R1, RespData, Timeout
   );

   modport slave (
      input  Start, CmdIndex, CmdArg, RespLen, HoldCs, ByteStrobe, RxByte,
      output TxByte, SpiEnable, SdCsN, Busy, Done, R1, RespData, Timeout
   );

endinterface

// File: rtl/sd_crc7.sv
// Byte-serial CRC7 accumulator: one byte folded in per cycle on load, zeroed on clear.
module sd_crc7
   import sd_spi_pkg::*;
(
   input  logic       Clk,
   input  logic       Reset,
   input  logic       clear,
   input  logic       load,
   input  logic [7:0] data,
   output logic [6:0] crc
);

   logic [6:0] crc_q, crc_d;

   always_comb begin
      crc_d = crc_q;
      if (clear) begin
         crc_d = '0;
      end else if (load) begin
         crc_d = crc7_update(crc_q, data);
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         crc_q <= '0;
      end else begin
         crc_q <= crc_d;
      end
   end

   assign crc = crc_q;

endmodule

// File: rtl/sd_cmd_sequencer.sv
// SD SPI-mode command engine: emits the 6-byte command frame byte by byte, polls for R1
// and optionally collects the 4-byte R3/R7 trailer, driving chip-select and clock enable.
module sd_cmd_sequencer
   import sd_spi_pkg::*;
#(
   parameter int unsigned TIMEOUT_BYTES = 8
) (
   input  logic               Clk,
   input  logic               Reset,
   sd_cmd_sequencer_if.slave  bus
);

   seq_state_e  state_q, state_d;

   logic [2:0]  byte_cnt_q, byte_cnt_d;
   logic [7:0]  wait_cnt_q, wait_cnt_d;
   logic [5:0]  idx_q, idx_d;
   logic [31:0] arg_q, arg_d;
   logic        resp_len_q, resp_len_d;
   logic        hold_cs_q, hold_cs_d;
   logic [7:0]  tx_q, tx_d;
   logic        spi_en_q, spi_en_d;
   logic        cs_n_q, cs_n_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [7:0]  r1_q, r1_d;
   logic [31:0] resp_data_q, resp_data_d;
   logic        timeout_q, timeout_d;

   logic        crc_clear, crc_load;
   logic [7:0]  crc_data;
   logic [6:0]  crc;

   logic        start_ok;
   logic        strobe;
   logic        r1_hit;
   logic [7:0]  wait_inc;
   logic        wait_expired;
   logic [7:0]  next_cmd_byte;

   // A Start landing on the Done cycle is dropped, even though the FSM is already idle
   assign start_ok     = bus.Start && (state_q == StIdle) && !done_q;
   assign strobe       = bus.ByteStrobe;
   assign r1_hit       = !bus.RxByte[7];
   assign wait_inc     = wait_cnt_q + 8'd1;
   assign wait_expired = (wait_inc == 8'(TIMEOUT_BYTES));

   // byte_cnt_q names the frame byte just finished; select the one that follows it
   always_comb begin
      unique case (byte_cnt_q)
         3'd0:    next_cmd_byte = arg_q[31:24];
         3'd1:    next_cmd_byte = arg_q[23:16];
         3'd2:    next_cmd_byte = arg_q[15:8];
         3'd3:    next_cmd_byte = arg_q[7:0];
         default: next_cmd_byte = {crc, 1'b1};
      endcase
   end

   sd_crc7 u_crc7 (
      .Clk   (Clk),
      .Reset (Reset),
      .clear (crc_clear),
      .load  (crc_load),
      .data  (crc_data),
      .crc   (crc)
   );

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:   if (start_ok) state_d = StPre;
         StPre:    if (strobe) state_d = StCmd;
         StCmd:    if (strobe && byte_cnt_q == 3'd5) state_d = StWaitR1;
         StWaitR1: begin
            if (strobe) begin
               if (r1_hit) begin
                  state_d = resp_len_q ? StExt : StPost;
               end else if (wait_expired) begin
                  state_d = StPost;
               end
            end
         end
         StExt:    if (strobe && byte_cnt_q == 3'd3) state_d = StPost;
         StPost:   if (strobe) state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_comb begin
      byte_cnt_d  = byte_cnt_q;
      wait_cnt_d  = wait_cnt_q;
      idx_d       = idx_q;
      arg_d       = arg_q;
      resp_len_d  = resp_len_q;
      hold_cs_d   = hold_cs_q;
      tx_d        = tx_q;
      spi_en_d    = spi_en_q;
      cs_n_d      = cs_n_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      r1_d        = r1_q;
      resp_data_d = resp_data_q;
      timeout_d   = timeout_q;
      crc_clear   = 1'b0;
      crc_load    = 1'b0;
      crc_data    = next_cmd_byte;

      case (state_q)
         StIdle: begin
            if (start_ok) begin
               idx_d      = bus.CmdIndex;
               arg_d      = bus.CmdArg;
               resp_len_d = bus.RespLen;
               hold_cs_d  = bus.HoldCs;
               timeout_d  = 1'b0;
               busy_d     = 1'b1;
               cs_n_d     = 1'b0;
               spi_en_d   = 1'b1;
               tx_d       = FILL_BYTE;
               crc_clear  = 1'b1;
            end
         end
         StPre: begin
            if (strobe) begin
               tx_d       = {START_BITS, idx_q};
               crc_load   = 1'b1;
               crc_data   = {START_BITS, idx_q};
               byte_cnt_d = 3'd0;
            end
         end
         StCmd: begin
            if (strobe) begin
               byte_cnt_d = byte_cnt_q + 3'd1;
               if (byte_cnt_q == 3'd5) begin
                  tx_d       = FILL_BYTE;
                  wait_cnt_d = 8'd0;
               end else begin
                  tx_d     = next_cmd_byte;
                  // Only bytes 1..4 feed the CRC; byte 5 carries it
                  crc_load = (byte_cnt_q < 3'd4);
               end
            end
         end
         StWaitR1: begin
            if (strobe) begin
               if (r1_hit) begin
                  r1_d       = bus.RxByte;
                  byte_cnt_d = 3'd0;
               end else begin
                  wait_cnt_d = wait_inc;
                  if (wait_expired) begin
                     r1_d      = FILL_BYTE;
                     timeout_d = 1'b1;
                  end
               end
            end
         end
         StExt: begin
            if (strobe) begin
               resp_data_d = {resp_data_q[23:0], bus.RxByte};
               byte_cnt_d  = byte_cnt_q + 3'd1;
            end
         end
         StPost: begin
            if (strobe) begin
               spi_en_d = 1'b0;
               cs_n_d   = ~hold_cs_q;
               done_d   = 1'b1;
               busy_d   = 1'b0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         byte_cnt_q  <= 3'd0;
         wait_cnt_q  <= 8'd0;
         idx_q       <= 6'd0;
         arg_q       <= 32'd0;
         resp_len_q  <= 1'b0;
         hold_cs_q   <= 1'b0;
         tx_q        <= FILL_BYTE;
         spi_en_q    <= 1'b0;
         cs_n_q      <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         r1_q        <= FILL_BYTE;
         resp_data_q <= 32'd0;
         timeout_q   <= 1'b0;
      end else begin
         byte_cnt_q  <= byte_cnt_d;
         wait_cnt_q  <= wait_cnt_d;
         idx_q       <= idx_d;
         arg_q       <= arg_d;
         resp_len_q  <= resp_len_d;
         hold_cs_q   <= hold_cs_d;
         tx_q        <= tx_d;
         spi_en_q    <= spi_en_d;
         cs_n_q      <= cs_n_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         r1_q        <= r1_d;
         resp_data_q <= resp_data_d;
         timeout_q   <= timeout_d;
      end
   end

   assign bus.TxByte    = tx_q;
   assign bus.SpiEnable = spi_en_q;
   assign bus.SdCsN     = cs_n_q;
   assign bus.Busy      = busy_q;
   assign bus.Done      = done_q;
   assign bus.R1        = r1_q;
   assign bus.RespData  = resp_data_q;
   assign bus.Timeout   = timeout_q;

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Bench for sd_cmd_sequencer: an emulated shifter/card drives byte strobes while a queue of
// expected TxBytes is checked byte by byte; table vectors plus reset/Start-injection cases.
module tb_sd_cmd_sequencer;
   import sd_spi_pkg::*;

   localparam int TIMEOUT = 8;

   typedef struct {
      logic [5:0]   idx;
      logic [31:0]  arg;
      logic         resp_len;
      logic         hold;
      int           n_rsp;
      logic [127:0] rsp;
      logic [7:0]   exp_r1;
      logic         exp_to;
      logic [31:0]  exp_data;
   } vec_t;

   logic Clk = 1'b0;
   logic Reset;

   int   n_checks = 0;
   int   n_errors = 0;
   logic last_csn;
   logic [7:0] exp_q[$];
   vec_t vecs [7];
   vec_t iv;

   sd_cmd_sequencer_if sif ();

   sd_cmd_sequencer #(
      .TIMEOUT_BYTES (TIMEOUT)
   ) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (sif)
   );

   always #5 Clk = ~Clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: actual still running, required finished");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: actual %h required %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Reference CRC7 by long division of the 40-bit message
   function automatic logic [6:0] crc7_ref(logic [39:0] msg);
      logic [46:0] r;
      r = {msg, 7'b0};
      for (int i = 46; i >= 7; i--) begin
         if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
      end
      return r[6:0];
   endfunction

   function automatic logic [7:0] rsp_byte(vec_t v, int i);
      logic [127:0] r;
      r = v.rsp;
      if (i < v.n_rsp) return r[127 - 8*i -: 8];
      return 8'hFF;
   endfunction

   task automatic run_cmd(input vec_t v, input int inject_at, input bit inject_done);
      int p, w, ext, n, exp_n, done_cnt, cycles;
      logic [7:0]  b, exp_b;
      logic [39:0] frame;
      p = -1;
      for (int i = 0; i < TIMEOUT; i++) begin
         b = rsp_byte(v, i);
         if (p < 0 && !b[7]) p = i;
      end
      w     = (p < 0) ? TIMEOUT : p + 1;
      ext   = (v.resp_len && p >= 0) ? 4 : 0;
      frame = {2'b01, v.idx, v.arg};
      exp_q.delete();
      exp_q.push_back(8'hFF);
      for (int i = 0; i < 5; i++) exp_q.push_back(frame[39 - 8*i -: 8]);
      exp_q.push_back({crc7_ref(frame), 1'b1});
      for (int i = 0; i < w + ext + 1; i++) exp_q.push_back(8'hFF);
      exp_n = exp_q.size();

      check("cs_before_start", 32'(sif.SdCsN), 32'(last_csn));
      check("busy_before_start", 32'(sif.Busy), 0);
      sif.CmdIndex = v.idx;
      sif.CmdArg   = v.arg;
      sif.RespLen  = v.resp_len;
      sif.HoldCs   = v.hold;
      sif.Start    = 1'b1;
      tick();
      sif.Start = 1'b0;
      check("cs_low_after_start", 32'(sif.SdCsN), 0);
      check("spi_en_after_start", 32'(sif.SpiEnable), 1);
      check("busy_after_start", 32'(sif.Busy), 1);

      n = 0;
      done_cnt = 0;
      cycles = 0;
      while (done_cnt == 0 && cycles < 1000) begin
         tick();
         tick();
         cycles += 3;
         if (exp_q.size() > 0) begin
            exp_b = exp_q.pop_front();
            check("tx_byte", 32'(sif.TxByte), 32'(exp_b));
         end else begin
            n_checks++;
            n_errors++;
            $display("FAIL extra_byte: actual byte %0d required at most %0d bytes", n + 1, exp_n);
         end
         if (n == inject_at) begin
            sif.Start    = 1'b1;
            sif.CmdIndex = ~v.idx;
            sif.CmdArg   = ~v.arg;
         end
         sif.RxByte     = (n < 7) ? 8'hFF : rsp_byte(v, n - 7);
         sif.ByteStrobe = 1'b1;
         tick();
         sif.ByteStrobe = 1'b0;
         sif.Start      = 1'b0;
         sif.RxByte     = 8'hFF;
         n++;
         if (sif.Done) done_cnt++;
      end

      check("done_seen", 32'(done_cnt), 1);
      check("strobe_count", 32'(n), 32'(exp_n));
      check("busy_at_done", 32'(sif.Busy), 0);
      check("spi_en_at_done", 32'(sif.SpiEnable), 0);
      check("cs_at_done", 32'(sif.SdCsN), 32'(!v.hold));
      check("tx_at_done", 32'(sif.TxByte), 32'hFF);
      check("r1", 32'(sif.R1), 32'(v.exp_r1));
      check("timeout", 32'(sif.Timeout), 32'(v.exp_to));
      check("resp_data", sif.RespData, v.exp_data);

      if (inject_done) sif.Start = 1'b1;
      tick();
      sif.Start = 1'b0;
      check("done_pulse_width", 32'(sif.Done), 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         if (sif.Done) done_cnt++;
      end
      check("done_once", 32'(done_cnt), 1);
      check("busy_after_done", 32'(sif.Busy), 0);
      check("cs_after_done", 32'(sif.SdCsN), 32'(!v.hold));
      last_csn = !v.hold;
   endtask

   initial begin
      vecs[0] = '{idx: CMD0, arg: 32'h0, resp_len: 1'b0, hold: 1'b0, n_rsp: 2,
                  rsp: {16'hFF01, 112'h0}, exp_r1: 8'h01, exp_to: 1'b0, exp_data: 32'h0};
      vecs[1] = '{idx: CMD8, arg: 32'h000001AA, resp_len: 1'b1, hold: 1'b0, n_rsp: 5,
                  rsp: {40'h01000001AA, 88'h0}, exp_r1: 8'h01, exp_to: 1'b0,
                  exp_data: 32'h000001AA};
      vecs[2] = '{idx: ACMD41, arg: 32'h40000000, resp_len: 1'b1, hold: 1'b0, n_rsp: 0,
                  rsp: 128'h0, exp_r1: 8'hFF, exp_to: 1'b1, exp_data: 32'h000001AA};
      vecs[3] = '{idx: CMD55, arg: 32'h0, resp_len: 1'b0, hold: 1'b0, n_rsp: 4,
                  rsp: {32'hFFFFFF01, 96'h0}, exp_r1: 8'h01, exp_to: 1'b0,
                  exp_data: 32'h000001AA};
      vecs[4] = '{idx: CMD17, arg: 32'h00000200, resp_len: 1'b0, hold: 1'b1, n_rsp: 2,
                  rsp: {16'hFF00, 112'h0}, exp_r1: 8'h00, exp_to: 1'b0,
                  exp_data: 32'h000001AA};
      vecs[5] = '{idx: CMD0, arg: 32'h0, resp_len: 1'b0, hold: 1'b0, n_rsp: 1,
                  rsp: {8'h01, 120'h0}, exp_r1: 8'h01, exp_to: 1'b0, exp_data: 32'h000001AA};
      // R1 on the last allowed wait byte, followed by a trailer
      vecs[6] = '{idx: CMD8, arg: 32'h000001AA, resp_len: 1'b1, hold: 1'b0, n_rsp: 12,
                  rsp: {56'hFFFFFFFFFFFFFF, 8'h05, 32'h12345678, 32'h0}, exp_r1: 8'h05,
                  exp_to: 1'b0, exp_data: 32'h12345678};

      sif.Start      = 1'b0;
      sif.CmdIndex   = '0;
      sif.CmdArg     = '0;
      sif.RespLen    = 1'b0;
      sif.HoldCs     = 1'b0;
      sif.ByteStrobe = 1'b0;
      sif.RxByte     = 8'hFF;
      Reset          = 1'b1;
      last_csn       = 1'b1;
      repeat (3) tick();
      Reset = 1'b0;
      tick();

      check("rst_tx", 32'(sif.TxByte), 32'hFF);
      check("rst_spi_en", 32'(sif.SpiEnable), 0);
      check("rst_cs", 32'(sif.SdCsN), 1);
      check("rst_busy", 32'(sif.Busy), 0);
      check("rst_done", 32'(sif.Done), 0);
      check("rst_r1", 32'(sif.R1), 32'hFF);
      check("rst_resp_data", sif.RespData, 0);
      check("rst_timeout", 32'(sif.Timeout), 0);

      sif.RxByte     = 8'h00;
      sif.ByteStrobe = 1'b1;
      tick();
      sif.ByteStrobe = 1'b0;
      sif.RxByte     = 8'hFF;
      tick();
      check("idle_strobe_busy", 32'(sif.Busy), 0);
      check("idle_strobe_r1", 32'(sif.R1), 32'hFF);
      check("idle_strobe_spi_en", 32'(sif.SpiEnable), 0);
      check("idle_strobe_tx", 32'(sif.TxByte), 32'hFF);

      // Reset while CMD byte 3 is on the wire
      sif.CmdIndex = CMD0;
      sif.CmdArg   = 32'h0;
      sif.RespLen  = 1'b0;
      sif.HoldCs   = 1'b0;
      sif.Start    = 1'b1;
      tick();
      sif.Start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         tick();
         sif.ByteStrobe = 1'b1;
         tick();
         sif.ByteStrobe = 1'b0;
      end
      check("mid_cmd_busy", 32'(sif.Busy), 1);
      check("mid_cmd_cs", 32'(sif.SdCsN), 0);
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      check("mid_rst_cs", 32'(sif.SdCsN), 1);
      check("mid_rst_spi_en", 32'(sif.SpiEnable), 0);
      check("mid_rst_tx", 32'(sif.TxByte), 32'hFF);
      check("mid_rst_busy", 32'(sif.Busy), 0);
      tick();
      last_csn = 1'b1;

      for (int k = 0; k < 7; k++) run_cmd(vecs[k], -1, 1'b0);

      // Start during CMD and on the Done cycle must both be dropped
      iv = vecs[0];
      iv.exp_data = 32'h12345678;
      run_cmd(iv, 3, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
